// File: rtl/pc_gen.sv
// Registered program counter: issues the PC to the IFU, resolves the next PC on commit,
// counts retired instructions. Define PCGEN_MISALIGN_TRAP_EN to trap misaligned targets.
module pc_gen #(
  parameter int unsigned      XLEN     = 32,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(32'h8000_0000),
  parameter int unsigned      INST_B   = 4,
  parameter int unsigned      CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  output logic             fetch_valid,
  input  logic             fetch_ready,
  output logic [XLEN-1:0]  fetch_pc,
  input  logic             commit_valid,
  output logic             commit_ready,
  input  logic             is_ecall,
  input  logic             is_mret,
  input  logic             jump_flag,
  input  logic             branch_flag,
  input  logic             halt,
  input  logic [XLEN-1:0]  exu_res,
  input  logic [XLEN-1:0]  branch_pc,
  input  logic [XLEN-1:0]  mtvec,
  input  logic [XLEN-1:0]  mepc,
  output logic [XLEN-1:0]  dnpc,
  output logic             halted,
  output logic [CNT_W-1:0] retired_cnt,
  output logic             misalign_trap
);

  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HALT} state_e;

  state_e           state_q, state_d;
  logic [XLEN-1:0]  pc_q, pc_d;
  logic [XLEN-1:0]  dnpc_q, dnpc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic             fetch_valid_q, commit_ready_q, halted_q;
  logic [XLEN-1:0]  target;
  logic             target_trap;

  // Next-PC resolution by priority: ecall > mret > jump > branch > sequential
  always_comb begin
    target      = pc_q + XLEN'(INST_B);
    target_trap = 1'b0;
    if (is_ecall)         target = mtvec & ~XLEN'(3);
    else if (is_mret)     target = mepc;
    else if (jump_flag)   target = exu_res & ~XLEN'(1);
    else if (branch_flag) target = branch_pc;
`ifdef PCGEN_MISALIGN_TRAP_EN
    if (!is_ecall && (is_mret || jump_flag || branch_flag) && (target[1:0] != 2'b00)) begin
      target      = mtvec & ~XLEN'(3);
      target_trap = 1'b1;
    end
`else
    target_trap = 1'b0;
`endif
  end

  // Next-state and register updates
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    dnpc_d  = dnpc_q;
    cnt_d   = cnt_q;
    trap_d  = 1'b0;
    case (state_q)
      ST_FETCH: if (fetch_ready) state_d = ST_WAIT;
      ST_WAIT: begin
        if (commit_valid) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (halt) begin
            state_d = ST_HALT;
          end else begin
            pc_d    = target;
            dnpc_d  = target;
            trap_d  = target_trap;
            state_d = ST_FETCH;
          end
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_FETCH;
      pc_q           <= RESET_PC;
      dnpc_q         <= RESET_PC;
      cnt_q          <= '0;
      trap_q         <= 1'b0;
      fetch_valid_q  <= 1'b1;
      commit_ready_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      dnpc_q         <= dnpc_d;
      cnt_q          <= cnt_d;
      trap_q         <= trap_d;
      fetch_valid_q  <= (state_d == ST_FETCH);
      commit_ready_q <= (state_d == ST_WAIT);
      halted_q       <= (state_d == ST_HALT);
    end
  end

  assign fetch_valid   = fetch_valid_q;
  assign commit_ready  = commit_ready_q;
  assign halted        = halted_q;
  assign fetch_pc      = pc_q;
  assign dnpc          = dnpc_q;
  assign retired_cnt   = cnt_q;
  assign misalign_trap = trap_q;

endmodule
